// File: rtl/modexp_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : modexp_scheduler
// Purpose  : Shares one modular-exponentiation engine among NREQ requesters.
//            Requests are picked round-robin. The winner's operands are
//            latched, the engine is launched with a single pulse, and the
//            engine result is returned to the winner only.
// Ports    : clk, rst (asynchronous, active-high)
//            req[NREQ], req_base/req_exp/req_mod[NREQ*W]  - requester side
//            grant[NREQ], rsp_valid[NREQ], rsp_result[RW], rsp_err, busy
//            eng_start, eng_base/eng_exp/eng_mod[W]        - engine launch
//            eng_result[RW], eng_done                      - engine return
// Options  : MODEXP_TIMEOUT_EN - enables the engine watchdog (TIMEOUT cycles)
// Revision : 1.0 - initial release
// ============================================================================
module modexp_scheduler #(
    parameter int NREQ    = 4,
    parameter int W       = 32,
    parameter int RW      = 64,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] req_base,
    input  logic [NREQ*W-1:0] req_exp,
    input  logic [NREQ*W-1:0] req_mod,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [RW-1:0]     rsp_result,
    output logic              rsp_err,
    output logic              busy,
    output logic              eng_start,
    output logic [W-1:0]      eng_base,
    output logic [W-1:0]      eng_exp,
    output logic [W-1:0]      eng_mod,
    input  logic [RW-1:0]     eng_result,
    input  logic              eng_done
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NREQ-1:0] c_one = NREQ'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_idx;

    logic            w_found;
    logic [IW-1:0]   w_pick;
    logic [3:0]      w_cand;
    logic [W-1:0]    w_mod;

`ifdef MODEXP_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]   r_cnt;
`else
    // The watchdog limit has no meaning without the watchdog.
    logic [31:0]     unused_timeout;
    assign unused_timeout = 32'(TIMEOUT);
`endif

    // Round-robin pick: first set request at or above the pointer, wrapping.
    // NREQ <= 8 keeps ptr+offset below 16, so a 4-bit candidate suffices.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = 4'(r_ptr) + 4'(k);
            if (w_cand >= 4'(NREQ)) begin
                w_cand = w_cand - 4'(NREQ);
            end
            if (!w_found && req[w_cand[IW-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_cand[IW-1:0];
            end
        end
    end

    assign w_mod = req_mod[w_pick*W +: W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_idx      <= '0;
            grant      <= '0;
            rsp_valid  <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
            eng_start  <= 1'b0;
            eng_base   <= '0;
            eng_exp    <= '0;
            eng_mod    <= '0;
`ifdef MODEXP_TIMEOUT_EN
            r_cnt      <= '0;
`endif
        end else begin
            // Pulsed outputs; rsp_result deliberately holds its last value.
            eng_start <= 1'b0;
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_idx    <= w_pick;
                        grant    <= c_one << w_pick;
                        busy     <= 1'b1;
                        eng_base <= req_base[w_pick*W +: W];
                        eng_exp  <= req_exp[w_pick*W +: W];
                        eng_mod  <= w_mod;
                        if (w_mod == '0) begin
                            // Result undefined for modulus 0: answer directly.
                            rsp_valid  <= c_one << w_pick;
                            rsp_result <= '0;
                            rsp_err    <= 1'b1;
                            r_state    <= S_RESP;
                        end else begin
                            eng_start <= 1'b1;
                            r_state   <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
`ifdef MODEXP_TIMEOUT_EN
                    r_cnt   <= '0;
`endif
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (eng_done) begin
                        rsp_valid  <= grant;
                        rsp_result <= eng_result;
                        r_state    <= S_RESP;
                    end
`ifdef MODEXP_TIMEOUT_EN
                    else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        rsp_valid  <= grant;
                        rsp_result <= '0;
                        rsp_err    <= 1'b1;
                        r_state    <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
`endif
                end
                S_RESP: begin
                    grant   <= '0;
                    busy    <= 1'b0;
                    // Served requester becomes lowest priority.
                    r_ptr   <= (r_idx == IW'(NREQ - 1)) ? '0 : r_idx + IW'(1);
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_modexp_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_modexp_scheduler
// Purpose  : Directed self-checking bench for modexp_scheduler with a
//            behavioural exponentiation engine of programmable latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_modexp_scheduler;

    localparam int NREQ = 4;
    localparam int W    = 32;
    localparam int RW   = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*W-1:0] req_base = '0;
    logic [NREQ*W-1:0] req_exp  = '0;
    logic [NREQ*W-1:0] req_mod  = '0;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   rsp_valid;
    logic [RW-1:0]     rsp_result;
    logic              rsp_err;
    logic              busy;
    logic              eng_start;
    logic [W-1:0]      eng_base;
    logic [W-1:0]      eng_exp;
    logic [W-1:0]      eng_mod;
    logic [RW-1:0]     eng_result = '0;
    logic              eng_done   = 1'b0;

    modexp_scheduler #(.NREQ(NREQ), .W(W), .RW(RW), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .req(req),
        .req_base(req_base), .req_exp(req_exp), .req_mod(req_mod),
        .grant(grant), .rsp_valid(rsp_valid), .rsp_result(rsp_result),
        .rsp_err(rsp_err), .busy(busy), .eng_start(eng_start),
        .eng_base(eng_base), .eng_exp(eng_exp), .eng_mod(eng_mod),
        .eng_result(eng_result), .eng_done(eng_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int starts = 0;
    int last_start = 0;
    int twohot = 0;
    int eng_lat = 3;
    logic eng_en = 1'b1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] modexp(input logic [31:0] b, input logic [31:0] e,
                                            input logic [31:0] m);
        logic [63:0] r, x;
        if (m == 0) return 64'd0;
        r = 64'd1 % {32'd0, m};
        x = {32'd0, b} % {32'd0, m};
        for (int i = 0; i < 32; i++) begin
            if (e[i]) r = (r * x) % {32'd0, m};
            x = (x * x) % {32'd0, m};
        end
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (eng_start) begin
            starts++;
            last_start = cyc;
        end
        if ($countones(grant) > 1 || $countones(rsp_valid) > 1) twohot++;
    end

    // Behavioural engine: answers eng_lat cycles after a launch.
    initial begin
        logic [31:0] b, e, m;
        forever begin
            @(negedge clk);
            if (eng_start && eng_en) begin
                b = eng_base; e = eng_exp; m = eng_mod;
                repeat (eng_lat) @(negedge clk);
                eng_result = modexp(b, e, m);
                eng_done   = 1'b1;
                @(negedge clk);
                eng_done   = 1'b0;
            end
        end
    end

    task automatic set_op(input int i, input logic [31:0] b, input logic [31:0] e,
                          input logic [31:0] m);
        req_base[i*W +: W] = b;
        req_exp[i*W +: W]  = e;
        req_mod[i*W +: W]  = m;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1; req = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("idle_reached", {63'd0, busy}, 64'd0);
    endtask

    // Waits (bounded) for a response; optionally drops the served request.
    task automatic serve(input logic drop, output logic [3:0] vec, output logic [63:0] res,
                         output logic err, output int at);
        vec = '0; res = '0; err = 1'b0; at = 0;
        for (int i = 0; i < 64 && vec == 0; i++) begin
            @(negedge clk);
            if (rsp_valid != 0) begin
                vec = rsp_valid; res = rsp_result; err = rsp_err; at = cyc;
                if (drop) req = req & ~rsp_valid;
            end
        end
    endtask

    initial begin
        logic [3:0]  vec;
        logic [63:0] res;
        logic        err;
        int          at, s0, npulse;
        logic [3:0]  exp_vec [5];
        logic [63:0] exp_res [5];

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_grant", {60'd0, grant}, 64'd0);
        check("rst_valid", {60'd0, rsp_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_start", {63'd0, eng_start}, 64'd0);
        check("rst_result", rsp_result, 64'd0);

        // Single request: 3^5 mod 7 = 5
        @(posedge clk); #1;
        set_op(0, 32'd3, 32'd5, 32'd7);
        req = 4'b0001;
        @(posedge clk); @(negedge clk);
        check("t2_grant", {60'd0, grant}, 64'd1);
        check("t2_start", {63'd0, eng_start}, 64'd1);
        check("t2_ops", {eng_base[15:0], eng_exp[15:0], eng_mod}, {16'd3, 16'd5, 32'd7});
        set_op(0, 32'd9, 32'd9, 32'd11);   // must not affect the running job
        serve(1'b1, vec, res, err, at);
        check("t2_vec", {60'd0, vec}, 64'd1);
        check("t2_res", res, 64'd5);
        check("t2_err", {63'd0, err}, 64'd0);
        check("t2_starts", 64'(starts), 64'd1);
        check("t2_latency", 64'(at - last_start), 64'(eng_lat + 1));

        // Two simultaneous requests: 0 first, then 2
        do_reset();
        set_op(0, 32'd2, 32'd10, 32'd1000);    // 1024 mod 1000 = 24
        set_op(2, 32'd5, 32'd3, 32'd13);       // 125 mod 13 = 8
        req = 4'b0101;
        serve(1'b1, vec, res, err, at);
        check("t3_first_vec", {60'd0, vec}, 64'd1);
        check("t3_first_res", res, 64'd24);
        serve(1'b1, vec, res, err, at);
        check("t3_second_vec", {60'd0, vec}, 64'd4);
        check("t3_second_res", res, 64'd8);

        // All four held: order 0,1,2,3,0
        do_reset();
        set_op(1, 32'd7, 32'd2, 32'd10);       // 49 mod 10 = 9
        set_op(3, 32'd2, 32'd5, 32'd31);       // 32 mod 31 = 1
        exp_vec = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_res = '{64'd24, 64'd9, 64'd8, 64'd1, 64'd24};
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            serve(1'b0, vec, res, err, at);
            check($sformatf("t4_vec%0d", i), {60'd0, vec}, {60'd0, exp_vec[i]});
            check($sformatf("t4_res%0d", i), res, exp_res[i]);
        end
        req = '0;

        // Zero modulus on requester 1
        wait_idle();
        s0 = starts;
        @(posedge clk); #1;
        set_op(1, 32'd7, 32'd2, 32'd0);
        req = 4'b0010;
        @(posedge clk); @(negedge clk);
        check("t5_vec", {60'd0, rsp_valid}, 64'd2);
        check("t5_res", rsp_result, 64'd0);
        check("t5_err", {63'd0, rsp_err}, 64'd1);
        check("t5_grant", {60'd0, grant}, 64'd2);
        req = '0;
        @(negedge clk);
        check("t5_pulse", {60'd0, rsp_valid}, 64'd0);
        check("t5_busy", {63'd0, busy}, 64'd0);
        check("t5_no_start", 64'(starts - s0), 64'd0);
        set_op(1, 32'd7, 32'd2, 32'd10);

        // Reset while waiting on the engine
        wait_idle();
        eng_lat = 8;
        @(posedge clk); #1;
        set_op(0, 32'd3, 32'd5, 32'd7);
        req = 4'b0001;
        @(posedge clk); @(negedge clk);
        check("t6_start", {63'd0, eng_start}, 64'd1);
        @(posedge clk); @(posedge clk);
        #1 rst = 1'b1; req = '0;
        #1;
        check("t6_rst_busy", {63'd0, busy}, 64'd0);
        check("t6_rst_grant", {60'd0, grant}, 64'd0);
        check("t6_rst_ops", {eng_base, eng_mod}, 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        npulse = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (rsp_valid != 0 || busy) npulse++;
        end
        check("t6_late_done_ignored", 64'(npulse), 64'd0);
        eng_lat = 3;
        @(posedge clk); #1 req = 4'b0100;
        serve(1'b1, vec, res, err, at);
        check("t6_after_vec", {60'd0, vec}, 64'd4);
        check("t6_after_res", res, 64'd8);

`ifdef MODEXP_TIMEOUT_EN
        // Engine never answers: watchdog fires after 16 WAIT cycles
        wait_idle();
        eng_en = 1'b0;
        @(posedge clk); #1 req = 4'b0001;
        serve(1'b1, vec, res, err, at);
        check("t7_vec", {60'd0, vec}, 64'd1);
        check("t7_err", {63'd0, err}, 64'd1);
        check("t7_res", res, 64'd0);
        check("t7_latency", 64'(at - last_start), 64'd17);
        @(negedge clk);
        check("t7_busy", {63'd0, busy}, 64'd0);
        eng_en = 1'b1;
`endif

        check("grant_onehot", 64'(twohot), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
